// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and helpers for the pushbutton conditioner.
//   btn_state_t : per-channel debounce FSM state encoding
//   cnt_width() : width of a counter that must hold values 0..cycles
// Optional feature macro used by the importing modules: BTN_REPEAT_EN.
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } btn_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 12500000;

    // Counter width able to represent 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: two-flop synchroniser, debounce FSM, registered level
// and one-cycle press pulse. With BTN_REPEAT_EN defined, a held button also
// re-pulses press_o every REPEAT_CYCLES cycles.
// Ports:
//   clock_i   : system clock, rising edge
//   reset_n_i : asynchronous active-low reset
//   btn_i     : raw button, asynchronous, active-high
//   level_o   : debounced level (registered)
//   press_o   : one-cycle pulse on an accepted press (registered)
// Macro: BTN_REPEAT_EN enables the auto-repeat counter.
// -----------------------------------------------------------------------------
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("debounce_channel: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             fresh_press;

    always_comb begin
        s1_d        = btn_i;
        s2_d        = s1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        fresh_press = 1'b0;

        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    // A single-cycle debounce window accepts the edge immediately.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d     = HELD;
                        fresh_press = 1'b1;
                    end else begin
                        state_d = ARMING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ARMING: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    fresh_press = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RELEASING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RELEASING: begin
                // Returning to HELD here is a release glitch, never a new press.
                if (s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        level_d = (state_d == HELD) || (state_d == RELEASING);
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned       RCNT_W    = cnt_width(REPEAT_CYCLES);
    localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              repeat_tick;

    // rcnt only advances in HELD, so RELEASING freezes it and a glitch that
    // lands back in HELD resumes the period where it left off.
    always_comb begin
        rcnt_d      = rcnt_q;
        repeat_tick = 1'b0;
        if (fresh_press) begin
            rcnt_d = '0;
        end else if (state_q == HELD) begin
            if (rcnt_q == RCNT_LAST) begin
                rcnt_d      = '0;
                repeat_tick = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RCNT_ONE;
            end
        end
        press_d = fresh_press | repeat_tick;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`else
    always_comb begin
        press_d = fresh_press;
    end
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronises and debounces NUM_INPUTS raw pushbutton inputs; each channel
// yields a clean level and a one-cycle press pulse.
// Ports:
//   clock_i   : system clock, rising edge
//   reset_n_i : asynchronous active-low reset
//   btn_i     : raw buttons [NUM_INPUTS-1:0], asynchronous, active-high
//   level_o   : debounced levels [NUM_INPUTS-1:0]
//   press_o   : press pulses [NUM_INPUTS-1:0]
// Macro: BTN_REPEAT_EN adds auto-repeat pulses every REPEAT_CYCLES while held.
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned NUM_INPUTS      = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic [NUM_INPUTS-1:0] btn_i,
    output logic [NUM_INPUTS-1:0] level_o,
    output logic [NUM_INPUTS-1:0] press_o
);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clock_i   (clock_i),
            .reset_n_i (reset_n_i),
            .btn_i     (btn_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Tick n of a scenario is the n-th rising edge after its stimulus was applied,
// so a stable input gives level/press high at tick DEBOUNCE_CYCLES+2.
// Macro: BTN_REPEAT_EN selects the auto-repeat expectations.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int RPT = 8;
`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] btn;
    logic [1:0] level_o;
    logic [1:0] press_o;

    int n_cmp;
    int n_err;

    button_conditioner #(
        .NUM_INPUTS      (2),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .btn_i     (btn),
        .level_o   (level_o),
        .press_o   (press_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        btn = 2'b00;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        logic [1:0] el, ep;
        rst_n = 1'b0;
        btn   = 2'b11;
        repeat (3) tick();
        n_cmp++;
        if (level_o !== 2'b00) begin
            n_err++;
            $display("FAIL reset_level got=%b want=00", level_o);
        end
        n_cmp++;
        if (press_o !== 2'b00) begin
            n_err++;
            $display("FAIL reset_press got=%b want=00", press_o);
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            el = (t >= 6) ? 2'b11 : 2'b00;
            ep = (t == 6) ? 2'b11 : 2'b00;
            n_cmp++;
            if (level_o !== el) begin
                n_err++;
                $display("FAIL reset_release_level t=%0d got=%b want=%b", t, level_o, el);
            end
            n_cmp++;
            if (press_o !== ep) begin
                n_err++;
                $display("FAIL reset_release_press t=%0d got=%b want=%b", t, press_o, ep);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] el, ep;
        for (int t = 1; t <= 26; t++) begin
            btn = (t <= 20) ? 2'b10 : 2'b00;
            tick();
            el = (t >= 6 && t <= 25) ? 2'b10 : 2'b00;
            ep = (t == 6 || (REP && (t == 14 || t == 22))) ? 2'b10 : 2'b00;
            n_cmp++;
            if (level_o !== el) begin
                n_err++;
                $display("FAIL clean_level t=%0d got=%b want=%b", t, level_o, el);
            end
            n_cmp++;
            if (press_o !== ep) begin
                n_err++;
                $display("FAIL clean_press t=%0d got=%b want=%b", t, press_o, ep);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        logic [1:0] el, ep;
        int         pulses;
        pattern = 5'b01101;
        pulses  = 0;
        for (int t = 1; t <= 17; t++) begin
            btn = {1'b0, (t <= 5) ? pattern[t-1] : 1'b1};
            tick();
            if (press_o[0]) pulses++;
            el = (t >= 11) ? 2'b01 : 2'b00;
            ep = (t == 11) ? 2'b01 : 2'b00;
            n_cmp++;
            if (level_o !== el) begin
                n_err++;
                $display("FAIL bounce_level t=%0d got=%b want=%b", t, level_o, el);
            end
            n_cmp++;
            if (press_o !== ep) begin
                n_err++;
                $display("FAIL bounce_press t=%0d got=%b want=%b", t, press_o, ep);
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL bounce_pulse_count got=%0d want=1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] el, ep;
        for (int t = 1; t <= 13; t++) begin
            btn = (t == 8 || t == 9) ? 2'b10 : 2'b11;
            tick();
            el = (t >= 6) ? 2'b11 : 2'b00;
            ep = (t == 6) ? 2'b11 : 2'b00;
            n_cmp++;
            if (level_o !== el) begin
                n_err++;
                $display("FAIL simul_level t=%0d got=%b want=%b", t, level_o, el);
            end
            n_cmp++;
            if (press_o !== ep) begin
                n_err++;
                $display("FAIL simul_press t=%0d got=%b want=%b", t, press_o, ep);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] el, ep;
        btn = 2'b10;
        repeat (6) tick();
        btn = 2'b11;
        repeat (4) tick();
        // ch1 is HELD, ch0 is ARMING with cnt=2
        n_cmp++;
        if (level_o !== 2'b10) begin
            n_err++;
            $display("FAIL mid_pre_level got=%b want=10", level_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (level_o !== 2'b00) begin
            n_err++;
            $display("FAIL mid_async_level got=%b want=00", level_o);
        end
        n_cmp++;
        if (press_o !== 2'b00) begin
            n_err++;
            $display("FAIL mid_async_press got=%b want=00", press_o);
        end
        repeat (2) tick();
        n_cmp++;
        if (level_o !== 2'b00) begin
            n_err++;
            $display("FAIL mid_hold_level got=%b want=00", level_o);
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            el = (t >= 6) ? 2'b11 : 2'b00;
            ep = (t == 6) ? 2'b11 : 2'b00;
            n_cmp++;
            if (level_o !== el) begin
                n_err++;
                $display("FAIL mid_release_level t=%0d got=%b want=%b", t, level_o, el);
            end
            n_cmp++;
            if (press_o !== ep) begin
                n_err++;
                $display("FAIL mid_release_press t=%0d got=%b want=%b", t, press_o, ep);
            end
        end
    endtask

    task automatic test_repeat();
        logic [1:0] ep;
        int         pulses;
        int         want;
        pulses = 0;
        want   = REP ? 5 : 1;
        for (int t = 1; t <= 50; t++) begin
            btn = (t <= 40) ? 2'b10 : 2'b00;
            tick();
            if (press_o[1]) pulses++;
            ep = (t == 6 || (REP && (t == 14 || t == 22 || t == 30 || t == 38)))
                 ? 2'b10 : 2'b00;
            n_cmp++;
            if (press_o !== ep) begin
                n_err++;
                $display("FAIL repeat_press t=%0d got=%b want=%b", t, press_o, ep);
            end
        end
        n_cmp++;
        if (pulses != want) begin
            n_err++;
            $display("FAIL repeat_pulse_count got=%0d want=%0d", pulses, want);
        end
        n_cmp++;
        if (level_o !== 2'b00) begin
            n_err++;
            $display("FAIL repeat_final_level got=%b want=00", level_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        btn   = 2'b00;
        test_reset();
        go_idle();
        test_clean_press();
        go_idle();
        test_bounce();
        go_idle();
        test_simultaneous();
        go_idle();
        test_reset_mid();
        go_idle();
        test_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the counter in the board top levels.
- Takes raw, asynchronous, bouncing pushbutton/switch inputs and synchronises them to the system clock.
- Debounces each input and produces a clean level plus a one-cycle press pulse per channel.
- Typical use: level_o[0] drives counter clear; press_o[1] drives counter count, so one physical press gives exactly one increment.

Parameters:
- NUM_INPUTS, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a level change is accepted (minimum 1).
- REPEAT_CYCLES, 12500000, auto-repeat period in cycles; used only when BTN_REPEAT_EN is defined (minimum 1).

Ports:
- clock_i  input  1  system clock; all state is on its rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- btn_i  input  NUM_INPUTS  raw button inputs, active-high, asynchronous to clock_i.
- level_o  output  NUM_INPUTS  debounced, registered button level.
- press_o  output  NUM_INPUTS  registered one-cycle pulse on each accepted press.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - All synchroniser flops, counters and FSMs clear.
  - level_o = 0, press_o = 0.
  - State = IDLE.
  - Takes effect mid-debounce or mid-press; no pulse is emitted on reset release.
- Synchroniser: two-flop chain per channel; s2 is the synchronised input.
- Per-channel FSM states, with a debounce counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE (level 0, cnt 0): s2=1 → ARMING with cnt=1. If DEBOUNCE_CYCLES=1, go directly to HELD instead.
  - ARMING (level 0): s2=0 → IDLE, cnt=0 (a bounce restarts the count). s2=1 and cnt=DEBOUNCE_CYCLES-1 → HELD; else cnt+1.
  - HELD (level 1, cnt 0): s2=0 → RELEASING with cnt=1. If DEBOUNCE_CYCLES=1, go directly to IDLE instead.
  - RELEASING (level 1): s2=1 → HELD, cnt=0. s2=0 and cnt=DEBOUNCE_CYCLES-1 → IDLE; else cnt+1.
- Outputs:
  - level_o is registered and equals 1 in HELD and RELEASING.
  - press_o is high for exactly the one cycle following the ARMING→HELD (or IDLE→HELD) transition.
  - Release produces no pulse.
- Latency: btn_i held high from sampling edge E0 gives level_o/press_o high after edge E0+DEBOUNCE_CYCLES+1. Release has the same latency.
- Width/wrap: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Independence: channels are fully independent; simultaneous presses produce simultaneous pulses.
- Input hold: an input held indefinitely produces a single pulse (no repeat without the macro).

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - Each channel has a repeat counter rcnt of width $clog2(REPEAT_CYCLES+1), cleared on entry to HELD.
  - While in HELD, rcnt increments. When it reaches REPEAT_CYCLES-1, press_o pulses for one cycle and rcnt returns to 0.
  - Net effect: pulses repeat every REPEAT_CYCLES cycles while held.
  - RELEASING freezes rcnt. A return to HELD from RELEASING resumes the count without an extra pulse.
- Undefined: no repeat logic or registers are synthesised; REPEAT_CYCLES is ignored.

Decomposition:
- Package button_pkg:
  - btn_state_t enum {IDLE, ARMING, HELD, RELEASING}.
  - Counter-width helper constants derived with $clog2.
- Sub-module debounce_channel:
  - One synchroniser, FSM and counters per input.
  - Instantiated NUM_INPUTS times in a generate loop by button_conditioner.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8.
- Reset: btn_i=2'b11 during reset, release reset_n_i → no press_o pulse, level_o=2'b11 exactly 5 edges after release, press_o=2'b11 for one cycle.
- Clean press on ch1: btn_i[1] rises at edge 0, held 20 cycles → level_o[1]=1 after edge 5, press_o[1] high one cycle only, release → level_o[1]=0 five edges after fall, no pulse.
- Bounce: btn_i[0] toggles 1,0,1,1,0 at 1-cycle intervals, then stable 1 → level_o[0] unchanged during bouncing, rises 5 edges after final rise, exactly one pulse.
- Simultaneous/independent: both channels rise same edge → press_o=2'b11 same cycle; ch0 release glitch of 2 cycles while held → level_o[0] stays 1, no pulse.
- Reset mid-operation: assert reset_n_i in ARMING (cnt=2) → outputs 0 immediately and asynchronously; after release with btn still high → full 5-edge latency again.
- BTN_REPEAT_EN: hold btn_i[1] for 40 cycles → pulses at HELD entry and every 8 cycles after (5 total within window); same test without macro → exactly 1 pulse.
